// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl: pipeline sequencing controller for the rv32im core.
//
// It generates per-stage register enables and NOP-insertion controls for the
// IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also launches the divider and
// keeps a saturating count of stalled fetch cycles.
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   INIT     | post-reset hold, pipeline frozen for INIT_CYC cycles
//   RUN      | normal issue; resolves mem / div / branch / load-use
//   DIV_WAIT | divide launched, EX frozen until div_done
//   DIV_HOLD | divide finished during a memory stall; result held in EX
//
// Ports
//   clk1, a_reset_n              clock, asynchronous active-low reset
//   id_rs1/id_rs2, id_use_rs1/2  sources of the instruction in ID
//   ex_rd, ex_useRd, ex_is_load  destination info of the instruction in EX
//   ex_div, div_done             divide in EX, divider result pulse
//   br_taken                     EX resolved a taken branch/jump
//   mem_req, mem_ack             data-memory access pending / completing
//   cnt_clr                      synchronous clear of stall_cnt
//   if_en..wb_en                 per-stage register enables
//   id_flush, *_bubble           stage registers capture a NOP
//   div_start                    one-cycle divider launch
//   stall_cnt                    saturating count of stalled fetch cycles

module ex_pipe_ctrl #(
  parameter int W        = 32,
  parameter int R        = 5,
  parameter int INIT_CYC = 2
) (
  input  logic         clk1,
  input  logic         a_reset_n,
  input  logic [R-1:0] id_rs1,
  input  logic [R-1:0] id_rs2,
  input  logic         id_use_rs1,
  input  logic         id_use_rs2,
  input  logic [R-1:0] ex_rd,
  input  logic         ex_useRd,
  input  logic         ex_is_load,
  input  logic         ex_div,
  input  logic         div_done,
  input  logic         br_taken,
  input  logic         mem_req,
  input  logic         mem_ack,
  input  logic         cnt_clr,
  output logic         if_en,
  output logic         id_en,
  output logic         ex_en,
  output logic         mem_en,
  output logic         wb_en,
  output logic         id_flush,
  output logic         ex_bubble,
  output logic         mem_bubble,
  output logic         wb_bubble,
  output logic         div_start,
  output logic [W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DIV_HOLD = 2'd3
  } state_t;

  localparam logic [3:0]   INIT_LAST = 4'(INIT_CYC - 1);
  localparam logic [W-1:0] CNT_ONE   = W'(1);
  localparam logic [W-1:0] CNT_MAX   = '1;

  state_t       state_q, state_d;
  logic [3:0]   init_cnt_q, init_cnt_d;
  logic [W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_stall;
  logic lu;

  assign mem_stall = mem_req & ~mem_ack;
  assign lu = ex_is_load & ex_useRd & (ex_rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if_en      = 1'b0;
    id_en      = 1'b0;
    ex_en      = 1'b0;
    mem_en     = 1'b0;
    wb_en      = 1'b0;
    id_flush   = 1'b0;
    ex_bubble  = 1'b0;
    mem_bubble = 1'b0;
    wb_bubble  = 1'b0;
    div_start  = 1'b0;

    case (state_q)
      ST_INIT: begin
        id_flush   = 1'b1;
        ex_bubble  = 1'b1;
        mem_bubble = 1'b1;
        wb_bubble  = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = ST_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end

      ST_RUN, ST_DIV_HOLD: begin
        if (mem_stall) begin
          wb_en     = 1'b1;
          wb_bubble = 1'b1;
        end else if (state_q == ST_RUN && ex_div) begin
          // Launch cycle already freezes EX so the divide never issues twice.
          div_start  = 1'b1;
          mem_en     = 1'b1;
          wb_en      = 1'b1;
          mem_bubble = 1'b1;
          state_d    = ST_DIV_WAIT;
        end else begin
          // In DIV_HOLD the divide in EX is complete and simply retires here.
          state_d = ST_RUN;
          if_en   = 1'b1;
          id_en   = 1'b1;
          ex_en   = 1'b1;
          mem_en  = 1'b1;
          wb_en   = 1'b1;
          if (br_taken) begin
            id_flush  = 1'b1;
            ex_bubble = 1'b1;
          end else if (lu) begin
            if_en     = 1'b0;
            id_en     = 1'b0;
            ex_bubble = 1'b1;
          end
        end
      end

      ST_DIV_WAIT: begin
        if (mem_stall) begin
          // ex_en stays low so the divider result register keeps its value.
          wb_en     = 1'b1;
          wb_bubble = 1'b1;
          if (div_done) state_d = ST_DIV_HOLD;
        end else if (div_done) begin
          if_en   = 1'b1;
          id_en   = 1'b1;
          ex_en   = 1'b1;
          mem_en  = 1'b1;
          wb_en   = 1'b1;
          state_d = ST_RUN;
        end else begin
          mem_en     = 1'b1;
          wb_en      = 1'b1;
          mem_bubble = 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (state_q != ST_INIT && !if_en && stall_cnt_q != CNT_MAX) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk1 or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
module tb_ex_pipe_ctrl;

  // Narrow counter so saturation is reachable in a short run.
  localparam int W        = 8;
  localparam int R        = 5;
  localparam int INIT_CYC = 2;
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic if_en, id_en, ex_en, mem_en, wb_en;
    logic id_flush, ex_bubble, mem_bubble, wb_bubble, div_start;
  } ctl_t;

  logic         clk1 = 1'b0;
  logic         a_reset_n;
  logic [R-1:0] id_rs1, id_rs2, ex_rd;
  logic         id_use_rs1, id_use_rs2, ex_useRd, ex_is_load, ex_div;
  logic         div_done, br_taken, mem_req, mem_ack, cnt_clr;
  logic         if_en, id_en, ex_en, mem_en, wb_en;
  logic         id_flush, ex_bubble, mem_bubble, wb_bubble, div_start;
  logic [W-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  always #5 clk1 = ~clk1;

  ex_pipe_ctrl #(.W(W), .R(R), .INIT_CYC(INIT_CYC)) dut (
    .clk1(clk1), .a_reset_n(a_reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_useRd(ex_useRd), .ex_is_load(ex_is_load), .ex_div(ex_div),
    .div_done(div_done), .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .cnt_clr(cnt_clr),
    .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .wb_en(wb_en),
    .id_flush(id_flush), .ex_bubble(ex_bubble), .mem_bubble(mem_bubble),
    .wb_bubble(wb_bubble), .div_start(div_start), .stall_cnt(stall_cnt)
  );

  ctl_t act;
  assign act = {if_en, id_en, ex_en, mem_en, wb_en,
                id_flush, ex_bubble, mem_bubble, wb_bubble, div_start};

  // Reference model: pipeline situation tracked as "cycles left in init",
  // "a divide is outstanding" and "a finished divide is stuck behind memory".
  int           init_left;
  bit           div_busy, div_held;
  logic [W-1:0] cnt_m;
  ctl_t         e;
  logic         m_stall, m_lu;

  always_comb begin
    e       = '0;
    m_stall = mem_req && !mem_ack;
    m_lu    = ex_is_load && ex_useRd && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (!a_reset_n || init_left > 0) begin
      e.id_flush = 1; e.ex_bubble = 1; e.mem_bubble = 1; e.wb_bubble = 1;
    end else if (m_stall) begin
      e.wb_en = 1; e.wb_bubble = 1;
    end else if (div_busy && div_done) begin
      e.if_en = 1; e.id_en = 1; e.ex_en = 1; e.mem_en = 1; e.wb_en = 1;
    end else if (div_busy || (ex_div && !div_held)) begin
      e.mem_en = 1; e.wb_en = 1; e.mem_bubble = 1;
      e.div_start = !div_busy;
    end else begin
      e.if_en = 1; e.id_en = 1; e.ex_en = 1; e.mem_en = 1; e.wb_en = 1;
      if (br_taken) begin
        e.id_flush = 1; e.ex_bubble = 1;
      end else if (m_lu) begin
        e.if_en = 0; e.id_en = 0; e.ex_bubble = 1;
      end
    end
  end

  always @(posedge clk1 or negedge a_reset_n) begin
    if (!a_reset_n) begin
      init_left <= INIT_CYC;
      div_busy  <= 0;
      div_held  <= 0;
      cnt_m     <= '0;
    end else begin
      if (init_left > 0) begin
        init_left <= init_left - 1;
      end else if (m_stall) begin
        if (div_busy && div_done) begin
          div_busy <= 0;
          div_held <= 1;
        end
      end else if (div_busy) begin
        if (div_done) div_busy <= 0;
      end else if (div_held) begin
        div_held <= 0;
      end else if (ex_div) begin
        div_busy <= 1;
      end
      if (cnt_clr) cnt_m <= '0;
      else if (init_left == 0 && !e.if_en && cnt_m != CNT_MAX) cnt_m <= cnt_m + 1'b1;
    end
  end

  always @(negedge clk1) begin
    if (chk_on) begin
      n_vec++;
      if (act !== e || stall_cnt !== cnt_m) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: ctl got %b expected %b, stall_cnt got %0d expected %0d",
                 $time, act, e, stall_cnt, cnt_m);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_useRd = 0; ex_is_load = 0; ex_div = 0;
    div_done = 0; br_taken = 0; mem_req = 0; mem_ack = 0; cnt_clr = 0;
  endtask

  initial begin
    clear_in();
    a_reset_n = 1'b0;
    chk_on    = 1'b1;
    tick(); tick();
    settle();
    pin("rst_en",  {if_en, id_en, ex_en, mem_en, wb_en}, 32'h00);
    pin("rst_bub", {id_flush, ex_bubble, mem_bubble, wb_bubble}, 32'hf);
    pin("rst_cnt", stall_cnt, 32'd0);

    // Release reset: two held cycles, then all enables up.
    a_reset_n = 1'b1;
    settle();
    pin("init_c0_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h00);
    tick(); settle();
    pin("init_c1_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h00);
    tick(); settle();
    pin("run_en",  {if_en, id_en, ex_en, mem_en, wb_en}, 32'h1f);
    pin("run_cnt", stall_cnt, 32'd0);

    // Load x5 in EX, ID reads rs2 = x5.
    ex_is_load = 1; ex_useRd = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    settle();
    pin("lu_if_id", {if_en, id_en}, 32'h0);
    pin("lu_ex_bubble", ex_bubble, 32'h1);
    pin("lu_ex_en", ex_en, 32'h1);
    tick(); clear_in(); settle();
    pin("lu_penalty_if", if_en, 32'h1);
    pin("lu_cnt", stall_cnt, 32'd1);

    // Same pattern with rd = x0: no hazard.
    ex_is_load = 1; ex_useRd = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    settle();
    pin("x0_if_en", if_en, 32'h1);
    tick(); clear_in(); settle();
    pin("x0_cnt", stall_cnt, 32'd1);

    // Divide, done after 33 cycles.
    ex_div = 1;
    settle();
    pin("div_start_c0", div_start, 32'h1);
    pin("div_memb_c0", mem_bubble, 32'h1);
    tick(); settle();
    pin("div_start_c1", div_start, 32'h0);
    pin("div_memb_c1", mem_bubble, 32'h1);
    repeat (32) tick();
    div_done = 1;
    settle();
    pin("div_done_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h1f);
    pin("div_done_memb", mem_bubble, 32'h0);
    tick(); clear_in(); settle();
    pin("div_cnt", stall_cnt, 32'd34);

    // Branch with a concurrent load-use: branch wins.
    ex_is_load = 1; ex_useRd = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; br_taken = 1;
    settle();
    pin("br_if_en", if_en, 32'h1);
    pin("br_id_flush", id_flush, 32'h1);
    pin("br_ex_bubble", ex_bubble, 32'h1);
    tick(); clear_in(); settle();
    pin("br_cnt", stall_cnt, 32'd34);

    // Saturation and clear.
    cnt_clr = 1;
    tick(); cnt_clr = 0; settle();
    pin("clr_cnt", stall_cnt, 32'd0);
    mem_req = 1;
    settle();
    pin("ms_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h01);
    pin("ms_wbb", wb_bubble, 32'h1);
    repeat (300) tick();
    settle();
    pin("sat_cnt", stall_cnt, 32'hff);
    cnt_clr = 1;
    tick(); cnt_clr = 0; settle();
    pin("sat_clr", stall_cnt, 32'd0);
    tick(); settle();
    pin("after_clr", stall_cnt, 32'd1);
    mem_ack = 1;
    settle();
    pin("ack_same_cycle", if_en, 32'h1);
    tick(); clear_in();

    // div_done lands inside a 3-cycle memory stall.
    ex_div = 1;
    tick(); tick(); tick();
    div_done = 1; mem_req = 1;
    settle();
    pin("hold_entry_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h01);
    pin("hold_entry_ds", div_start, 32'h0);
    tick(); div_done = 0; settle();
    pin("hold_ds", div_start, 32'h0);
    pin("hold_if", if_en, 32'h0);
    tick();
    mem_ack = 1;
    settle();
    pin("hold_rel_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h1f);
    pin("hold_rel_ds", div_start, 32'h0);
    tick(); clear_in();

    // Reset asserted while waiting on the divider.
    ex_div = 1;
    tick(); tick(); settle();
    pin("mr_pre_memb", mem_bubble, 32'h1);
    a_reset_n = 1'b0;
    settle();
    pin("mr_en",  {if_en, id_en, ex_en, mem_en, wb_en}, 32'h00);
    pin("mr_bub", {id_flush, ex_bubble, mem_bubble, wb_bubble}, 32'hf);
    pin("mr_ds",  div_start, 32'h0);
    pin("mr_cnt", stall_cnt, 32'd0);
    clear_in();
    tick(); tick();
    a_reset_n = 1'b1;
    tick(); tick(); tick(); settle();
    pin("post_rst_en", {if_en, id_en, ex_en, mem_en, wb_en}, 32'h1f);
    pin("post_rst_ds", div_start, 32'h0);
    repeat (3) tick();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
